// File: rtl/mole_spawner.sv
// mole_spawner
//   Produces the mole pattern for the whack-a-mole datapath. Each round has
//   three phases. GAP shows no moles for DOWN_TICKS cycles. SPAWN builds a
//   random pattern of 1..MAX_MOLES moles, adding one mole per cycle, while
//   the output stays dark. UP shows the pattern until it times out or the
//   player clears it. Every full clear shortens the up-time, down to a floor.
//
// Ports
//   clk               system clock; all state changes on the rising edge
//   reset             asynchronous, active-high
//   game_in_progress  high while a game runs; low sends the block to IDLE
//   full_clear_hit    1-cycle pulse from hit detection; the last mole was hit
//   mole_positions    one bit per hole for each raised mole; 0 when none are up
//   moles_up          high exactly while in UP
//   round_count       rounds spawned in the current game; saturates at 255
//
// State table
//   state  | meaning
//   IDLE   | no game running; outputs dark
//   GAP    | dark pause between rounds; counter counts down to 0
//   SPAWN  | building the pattern, one mole per cycle; output still dark
//   UP     | pattern visible until timeout or full clear
module mole_spawner #(
  parameter int          NUM_HOLES     = 18,
  parameter int          MAX_MOLES     = 3,
  parameter int          DOWN_TICKS    = 25_000_000,
  parameter int          UP_TICKS_INIT = 50_000_000,
  parameter int          UP_TICKS_MIN  = 10_000_000,
  parameter int          UP_TICKS_STEP = 2_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_in_progress,
  input  logic                 full_clear_hit,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 moles_up,
  output logic [7:0]           round_count
);

  localparam int TICK_MAX_A = (DOWN_TICKS > UP_TICKS_INIT) ? DOWN_TICKS : UP_TICKS_INIT;
  localparam int TICK_MAX   = (TICK_MAX_A > UP_TICKS_MIN) ? TICK_MAX_A : UP_TICKS_MIN;
  // The counter only ever holds reload values (ticks - 1). The up-time
  // register must also hold the full UP_TICKS_INIT value, so it gets one
  // extra count of range.
  localparam int CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int UPT_W = $clog2(TICK_MAX + 1);
  localparam int IDX_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam int K_W   = $clog2(MAX_MOLES + 1);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  localparam logic [CNT_W-1:0] DOWN_RELOAD = CNT_W'(DOWN_TICKS - 1);
  localparam logic [UPT_W-1:0] UP_INIT     = UPT_W'(UP_TICKS_INIT);
  localparam logic [UPT_W-1:0] UP_FLOOR    = UPT_W'(UP_TICKS_MIN);
  localparam logic [UPT_W-1:0] UP_STEP     = UPT_W'(UP_TICKS_STEP);
  // The decrement is applied only when the result stays at or above the
  // floor. The compare runs on 33 bits so that the sum cannot wrap.
  localparam logic [32:0]      DEC_THRESH  = 33'(UP_TICKS_MIN) + 33'(UP_TICKS_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_SPAWN = 2'd2,
    S_UP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [UPT_W-1:0]     up_ticks_q, up_ticks_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_HOLES-1:0] pattern_q, pattern_d;
  logic [K_W-1:0]       left_q, left_d;
  logic [NUM_HOLES-1:0] mole_positions_q, mole_positions_d;
  logic                 moles_up_q, moles_up_d;
  logic [7:0]           round_count_q, round_count_d;

  int                   spawn_idx;
  logic [NUM_HOLES-1:0] spawn_pat;

  // Sets the lowest clear bit at or above start, wrapping to bit 0. The
  // caller never has every bit set, because MAX_MOLES <= NUM_HOLES.
  function automatic logic [NUM_HOLES-1:0] place_mole(
    input logic [NUM_HOLES-1:0] pat,
    input int                   start
  );
    logic [NUM_HOLES-1:0] onehot;
    logic                 found;
    int                   p;
    logic [IDX_W-1:0]     pi;
    onehot = '0;
    found  = 1'b0;
    for (int off = 0; off < NUM_HOLES; off++) begin
      p = start + off;
      if (p >= NUM_HOLES) p = p - NUM_HOLES;
      pi = IDX_W'(p);
      if (!found && !pat[pi]) begin
        onehot[pi] = 1'b1;
        found      = 1'b1;
      end
    end
    return pat | onehot;
  endfunction

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    up_ticks_d       = up_ticks_q;
    pattern_d        = pattern_q;
    left_d           = left_q;
    mole_positions_d = mole_positions_q;
    round_count_d    = round_count_q;

    // Fibonacci LFSR with taps 16,14,13,11. It runs in every state.
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    spawn_idx = int'({24'd0, lfsr_q[7:0]}) % NUM_HOLES;
    spawn_pat = place_mole(pattern_q, spawn_idx);

    if (!game_in_progress) begin
      state_d          = S_IDLE;
      mole_positions_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          round_count_d = 8'd0;
          up_ticks_d    = UP_INIT;
          cnt_d         = DOWN_RELOAD;
          state_d       = S_GAP;
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            left_d    = K_W'(int'({24'd0, lfsr_q[15:8]}) % MAX_MOLES + 1);
            pattern_d = '0;
            state_d   = S_SPAWN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SPAWN: begin
          pattern_d = spawn_pat;
          if (left_q == K_W'(1)) begin
            // Publish the finished pattern in one step. The hit detector
            // never sees a partly built pattern.
            mole_positions_d = spawn_pat;
            cnt_d            = CNT_W'(up_ticks_q - UPT_W'(1));
            round_count_d    = (round_count_q == 8'hFF) ? 8'hFF : round_count_q + 8'd1;
            state_d          = S_UP;
          end else begin
            left_d = left_q - K_W'(1);
          end
        end
        S_UP: begin
          if (full_clear_hit || cnt_q == '0) begin
            mole_positions_d = '0;
            cnt_d            = DOWN_RELOAD;
            state_d          = S_GAP;
            // A hit takes priority over a timeout in the same cycle. The
            // round counts as cleared and the up-time shrinks.
            if (full_clear_hit) begin
              up_ticks_d = (33'(up_ticks_q) >= DEC_THRESH) ? up_ticks_q - UP_STEP : UP_FLOOR;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    moles_up_d = (state_d == S_UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      up_ticks_q       <= UP_INIT;
      lfsr_q           <= SEED;
      pattern_q        <= '0;
      left_q           <= '0;
      mole_positions_q <= '0;
      moles_up_q       <= 1'b0;
      round_count_q    <= 8'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      up_ticks_q       <= up_ticks_d;
      lfsr_q           <= lfsr_d;
      pattern_q        <= pattern_d;
      left_q           <= left_d;
      mole_positions_q <= mole_positions_d;
      moles_up_q       <= moles_up_d;
      round_count_q    <= round_count_d;
    end
  end

  assign mole_positions = mole_positions_q;
  assign moles_up       = moles_up_q;
  assign round_count    = round_count_q;

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
Game-side producer of the mole pattern for the whack-a-mole datapath. It drives the mole_positions bus into the hit-detection block and consumes that block's full_clear_hit pulse. It runs a gap/spawn/up round cycle with an LFSR-driven random pattern of 1..MAX_MOLES moles. The up-time shrinks each time the player clears all moles of a round.

Parameters:
NUM_HOLES, 18, width of mole_positions; number of holes.
MAX_MOLES, 3, max moles per round; legal range 1..NUM_HOLES.
DOWN_TICKS, 25_000_000, clk cycles with no moles between rounds; must be >= 1.
UP_TICKS_INIT, 50_000_000, initial up-time in clk cycles.
UP_TICKS_MIN, 10_000_000, floor for up-time.
UP_TICKS_STEP, 2_000_000, up-time reduction per full clear.
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
game_in_progress  in  1  high while a game runs; low forces IDLE.
full_clear_hit  in  1  1-cycle pulse: last remaining mole of the round was hit.
mole_positions  out  NUM_HOLES  one-hot-per-hole pattern of raised moles; 0 when none are up.
moles_up  out  1  high exactly when state is UP.
round_count  out  8  rounds spawned in the current game, saturating at 255.

Behaviour:
- Reset (async): state=IDLE; mole_positions=0; moles_up=0; round_count=0; up_ticks=UP_TICKS_INIT; lfsr=seed; internal pattern=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle in every state except reset.
  - Never reaches 0.
- IDLE:
  - mole_positions=0.
  - When game_in_progress=1: round_count<=0, up_ticks<=UP_TICKS_INIT, counter<=DOWN_TICKS-1, go to GAP.
- GAP:
  - mole_positions=0; counter decrements each cycle.
  - At counter=0: k<=1+(lfsr[15:8] mod MAX_MOLES), pattern<=0, go to SPAWN.
- SPAWN:
  - Adds one mole per cycle into the internal pattern, over exactly k cycles. mole_positions stays 0 throughout.
  - Candidate idx=lfsr[7:0] mod NUM_HOLES.
  - If pattern[idx] is already set, use the lowest clear bit at or above idx, wrapping to 0.
  - After the k-th mole: mole_positions<=pattern (loaded in a single cycle, never partial), counter<=up_ticks-1, round_count<=sat(round_count+1), go to UP.
- UP:
  - moles_up=1; mole_positions held constant.
  - Exit when counter=0 (timeout) or full_clear_hit=1, whichever comes first. On exit: mole_positions<=0, counter<=DOWN_TICKS-1, go to GAP.
  - Exit on full_clear_hit (including when it coincides with counter=0): up_ticks<=max(up_ticks-UP_TICKS_STEP, UP_TICKS_MIN), using no-underflow arithmetic.
  - Exit on timeout alone: up_ticks unchanged. The downstream block scores the miss on the falling edge of mole_positions.
- full_clear_hit is ignored outside UP.
- game_in_progress=0 in any state: next edge goes to IDLE with mole_positions=0, moles_up=0. round_count holds its value for display; up_ticks is restored on the next game start.
- Counters are sized to $clog2 of the largest tick parameter.

Test Plan:
Common bench parameters: NUM_HOLES=18, MAX_MOLES=3, DOWN_TICKS=4, UP_TICKS_INIT=20, UP_TICKS_MIN=8, UP_TICKS_STEP=6.
1. Reset, then raise game_in_progress -> mole_positions=0 for 1 (IDLE) + 4 (GAP) + k (SPAWN) cycles; then popcount(mole_positions) in 1..3, round_count=1, moles_up=1.
2. No full_clear_hit -> mole_positions nonzero for exactly 20 cycles, then 0 for 4+k cycles; next UP also lasts 20 cycles; round_count=2.
3. Pulse full_clear_hit on cycle 5 of each UP -> mole_positions=0 on the next edge; the following full-length UPs last 14, 8, 8 cycles (floor reached).
4. Drop game_in_progress mid-UP -> mole_positions=0 and moles_up=0 next edge; round_count held. Re-raise -> round_count restarts at 1, UP lasts 20.
5. Assert reset mid-SPAWN -> all outputs 0 immediately (without waiting for clk); after release the first pattern matches the golden model from seed 16'hACE1.
6. Run 2000 rounds against a reference model -> bits above NUM_HOLES-1 never set; popcount in 1..3; mole_positions changes only on entering or leaving UP.
